shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 114 +++++++++++
 tb/tb_shift_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 16-bit shifter through a
// round-robin arbiter feeding a single-entry registered result stage.
module shift_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_amt,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_amt,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_id,
    input  logic        rsp_ready
);

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned OW = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            id_q, id_d;

    logic            slot_free;
    logic            grant0, grant1;
    logic [OW-1:0]   sel_op;
    logic [DW-1:0]   sel_data;
    logic [AW-1:0]   sel_amt;

    // Shared shifter: SLL, SRA, ROR, pass-through; amt 0 leaves data unchanged.
    function automatic logic [DW-1:0] shift_op(input logic [OW-1:0] op,
                                               input logic [DW-1:0] d,
                                               input logic [AW-1:0] amt);
        logic [2*DW-1:0] dbl;
        dbl = {d, d} >> amt;
        case (op)
            2'b00:   return d << amt;
            2'b01:   return DW'($signed(d) >>> amt);
            2'b10:   return dbl[DW-1:0];
            default: return d;
        endcase
    endfunction

    // State, pointer and result registers; reset discards any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    // Arbitration, grant handshakes and next-state selection.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        id_d       = id_q;
        grant0     = 1'b0;
        grant1     = 1'b0;

        // rsp_ready only frees the slot when a result is actually held.
        slot_free = (state_q == EMPTY) || rsp_ready;

        if (rst_n && slot_free) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~ptr_q;
                grant1 = ptr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end

        sel_op   = grant1 ? req1_op   : req0_op;
        sel_data = grant1 ? req1_data : req0_data;
        sel_amt  = grant1 ? req1_amt  : req0_amt;

        if (grant0 || grant1) begin
            state_d = FULL;
            data_d  = shift_op(sel_op, sel_data, sel_amt);
            id_d    = grant1;
            ptr_d   = ~grant1;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end

        req0_ready = grant0;
        req1_ready = grant1;
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: inputs change 1 ns after the rising edge,
// combinational readies are sampled 1 ns later, registered outputs 1 ns after
// the following rising edge.
module tb_shift_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [1:0]  req0_op;
    logic [15:0] req0_data;
    logic [3:0]  req0_amt;
    logic        req0_ready;
    logic        req1_valid;
    logic [1:0]  req1_op;
    logic [15:0] req1_data;
    logic [3:0]  req1_amt;
    logic        req1_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready;

    int checks = 0;
    int errors = 0;

    shift_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [15:0] d, input logic id);
        chk({tag, ".valid"}, 16'(rsp_valid), 16'(v));
        chk({tag, ".data"},  rsp_data,       d);
        chk({tag, ".id"},    16'(rsp_id),    16'(id));
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".ready0"}, 16'(req0_ready), 16'(r0));
        chk({tag, ".ready1"}, 16'(req1_ready), 16'(r1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    logic [1:0]  t_op  [11];
    logic [3:0]  t_amt [11];
    logic [15:0] t_exp [11];

    initial begin
        t_op[0]  = 2'b00; t_amt[0]  = 4'd0;  t_exp[0]  = 16'hA5A5;
        t_op[1]  = 2'b00; t_amt[1]  = 4'd15; t_exp[1]  = 16'h8000;
        t_op[2]  = 2'b01; t_amt[2]  = 4'd0;  t_exp[2]  = 16'hA5A5;
        t_op[3]  = 2'b01; t_amt[3]  = 4'd15; t_exp[3]  = 16'hFFFF;
        t_op[4]  = 2'b10; t_amt[4]  = 4'd0;  t_exp[4]  = 16'hA5A5;
        t_op[5]  = 2'b10; t_amt[5]  = 4'd15; t_exp[5]  = 16'h4B4B;
        t_op[6]  = 2'b11; t_amt[6]  = 4'd0;  t_exp[6]  = 16'hA5A5;
        t_op[7]  = 2'b11; t_amt[7]  = 4'd15; t_exp[7]  = 16'hA5A5;
        t_op[8]  = 2'b00; t_amt[8]  = 4'd4;  t_exp[8]  = 16'h5A50;
        t_op[9]  = 2'b01; t_amt[9]  = 4'd4;  t_exp[9]  = 16'hFA5A;
        t_op[10] = 2'b10; t_amt[10] = 4'd4;  t_exp[10] = 16'h5A5A;

        rst_n      = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_data = 16'h1234; req0_amt = 4'd1;
        req1_valid = 1'b1; req1_op = 2'b00; req1_data = 16'h5678; req1_amt = 4'd1;
        rsp_ready  = 1'b1;

        // Reset state, readies held low while in reset
        #22;
        chk_rsp("reset", 1'b0, 16'h0000, 1'b0);
        chk_rdy("reset", 1'b0, 1'b0);
        tick();
        chk_rsp("reset_clk", 1'b0, 16'h0000, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #4 rst_n = 1'b1;
        tick();
        chk_rsp("post_reset_idle", 1'b0, 16'h0000, 1'b0);

        // Single requester SLL
        req0_valid = 1'b1; req0_op = 2'b00; req0_data = 16'h00F1; req0_amt = 4'd4;
        rsp_ready = 1'b1;
        #1 chk_rdy("sll_acc", 1'b1, 1'b0);
        tick();
        chk_rsp("sll_rsp", 1'b1, 16'h0F10, 1'b0);
        req0_valid = 1'b0;
        #1 chk_rdy("drain_idle", 1'b0, 1'b0);
        tick();
        chk_rsp("drain", 1'b0, 16'h0F10, 1'b0);
        tick();
        chk_rsp("empty_rsp_ready", 1'b0, 16'h0F10, 1'b0);

        // Fairness: back-to-back alternating grants starting at req0
        do_reset();
        req0_valid = 1'b1; req0_op = 2'b01; req0_data = 16'h8000; req0_amt = 4'd3;
        req1_valid = 1'b1; req1_op = 2'b10; req1_data = 16'h0001; req1_amt = 4'd1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk_rdy($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1);
            tick();
            chk_rsp($sformatf("rr%0d", k), 1'b1, ((k % 2) == 0) ? 16'hF000 : 16'h8000, (k % 2) == 1);
        end

        // Stall: result held stable, no grants, pointer unchanged
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req1_data = 16'(16'h1111 * (k + 1));
            req0_amt  = 4'(k + 5);
            #1 chk_rdy($sformatf("stall%0d", k), 1'b0, 1'b0);
            tick();
            chk_rsp($sformatf("stall%0d", k), 1'b1, 16'h8000, 1'b1);
        end
        req0_amt = 4'd3;
        rsp_ready = 1'b1;
        #1 chk_rdy("unstall", 1'b1, 1'b0);
        tick();
        chk_rsp("unstall", 1'b1, 16'hF000, 1'b0);

        // Operation table on A5A5 via req0 only
        req1_valid = 1'b0;
        req0_data = 16'hA5A5;
        for (int k = 0; k < 11; k++) begin
            req0_op = t_op[k]; req0_amt = t_amt[k];
            tick();
            chk($sformatf("op%0d_amt%0d", t_op[k], t_amt[k]), rsp_data, t_exp[k]);
        end

        // Lone req1 granted regardless of pointer
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b00; req1_data = 16'h0003; req1_amt = 4'd2;
        #1 chk_rdy("lone1", 1'b0, 1'b1);
        tick();
        chk_rsp("lone1", 1'b1, 16'h000C, 1'b1);

        // Async reset while FULL and stalled; pointer left at req1 beforehand
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b11; req0_data = 16'hBEEF; req0_amt = 4'd0;
        tick();
        chk_rsp("pre_rst", 1'b1, 16'hBEEF, 1'b0);
        req0_valid = 1'b0;
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_rsp("async_rst", 1'b0, 16'h0000, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 chk_rdy("async_rst", 1'b0, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_rsp("after_rst", 1'b0, 16'h0000, 1'b0);
        req0_valid = 1'b1; req0_op = 2'b00; req0_data = 16'h0001; req0_amt = 4'd1;
        req1_valid = 1'b1; req1_op = 2'b00; req1_data = 16'h0001; req1_amt = 4'd2;
        rsp_ready = 1'b1;
        #1 chk_rdy("first_grant", 1'b1, 1'b0);
        tick();
        chk_rsp("first_grant", 1'b1, 16'h0002, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
